// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction handshake, ALU op/A/B/S/coms and writeback bus
interface alu_issue_ctrl_if #(
    parameter int DW = 16
);
    logic          instr_valid;
    logic [15:0]   instr;
    logic          instr_ready;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_s;
    logic          alu_coms;
    logic          wb_valid;
    logic [2:0]    wb_addr;
    logic [DW-1:0] wb_data;

    // The controller is the slave of the instruction stream and drives the ALU/writeback side.
    modport slave (
        input  instr_valid, instr, alu_s, alu_coms,
        output instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data
    );

    modport master (
        output instr_valid, instr, alu_s, alu_coms,
        input  instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - serialized issue controller: decode, register-file read, ALU drive, writeback
module alu_issue_ctrl #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_issue_ctrl_if.slave bus,
    output logic          illegal,
    output logic          busy,
    input  logic [2:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b1010;
    localparam logic [3:0] OP_SOE = 4'b1011;
    localparam logic [3:0] OP_LDI = 4'b1100;

    state_t        state;
    state_t        state_next;
    logic [15:0]   ir;
    logic [DW-1:0] rf [NREG];

    logic [3:0]    opc;
    logic [2:0]    rd;
    logic [2:0]    rs;
    logic [2:0]    rt;
    logic [7:0]    imm;
    logic          is_ldi;
    logic          is_illegal;
    logic          is_cmp;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          accept;

    assign opc        = ir[15:12];
    assign rd         = ir[11:9];
    assign rs         = ir[8:6];
    assign rt         = ir[5:3];
    assign imm        = ir[7:0];
    assign is_ldi     = (opc == OP_LDI);
    assign is_illegal = (opc > OP_LDI);
    assign is_cmp     = (opc == OP_SLT) || (opc == OP_SOE);

    // R0 is hardwired to zero on every read path.
    assign rs_data  = (rs == 3'd0) ? '0 : rf[rs];
    assign rt_data  = (rt == 3'd0) ? '0 : rf[rt];
    assign dbg_data = (dbg_addr == 3'd0) ? '0 : rf[dbg_addr];

    assign accept = bus.instr_valid && (state == S_IDLE);

    always_comb begin
        state_next      = state;
        bus.instr_ready = 1'b0;
        illegal         = 1'b0;
        busy            = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                bus.instr_ready = !rst;
                if (bus.instr_valid && !rst) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_illegal) begin
                    illegal    = !rst;
                    state_next = S_IDLE;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC:  state_next = S_WB;
            S_WB:    state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ir           <= '0;
            bus.alu_op   <= '0;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.wb_valid <= 1'b0;
            bus.wb_addr  <= '0;
            bus.wb_data  <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            state        <= state_next;
            bus.wb_valid <= (state == S_EXEC);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ir <= bus.instr;
                    end
                end
                S_DECODE: begin
                    // An illegal opcode leaves the ALU operands exactly as they were.
                    if (!is_illegal) begin
                        if (is_ldi) begin
                            bus.alu_op <= OP_ADD;
                            bus.alu_a  <= {{(DW-8){1'b0}}, imm};
                            bus.alu_b  <= '0;
                        end else begin
                            bus.alu_op <= opc;
                            bus.alu_a  <= rs_data;
                            bus.alu_b  <= rt_data;
                        end
                    end
                end
                S_EXEC: begin
                    bus.wb_addr <= rd;
                    bus.wb_data <= is_cmp ? {{(DW-1){1'b0}}, bus.alu_coms} : bus.alu_s;
                end
                S_WB: begin
                    if (rd != 3'd0) begin
                        rf[rd] <= bus.wb_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        illegal;
    logic        busy;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_rf [8];

    alu_issue_ctrl_if #(.DW(16)) bus ();

    alu_issue_ctrl #(.DW(16), .NREG(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .illegal  (illegal),
        .busy     (busy),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // Reference ALU: AND OR XOR ADD SUB SLL SRA SRL NOT COM SLT SOE.
    always_comb begin
        bus.alu_s    = '0;
        bus.alu_coms = 1'b0;
        case (bus.alu_op)
            4'h0: bus.alu_s = bus.alu_a & bus.alu_b;
            4'h1: bus.alu_s = bus.alu_a | bus.alu_b;
            4'h2: bus.alu_s = bus.alu_a ^ bus.alu_b;
            4'h3: bus.alu_s = bus.alu_a + bus.alu_b;
            4'h4: bus.alu_s = bus.alu_a - bus.alu_b;
            4'h5: bus.alu_s = bus.alu_a << bus.alu_b;
            4'h6: bus.alu_s = $signed(bus.alu_a) >>> bus.alu_b;
            4'h7: bus.alu_s = bus.alu_a >> bus.alu_b;
            4'h8: bus.alu_s = ~bus.alu_a;
            4'h9: bus.alu_s = -bus.alu_a;
            4'hA: bus.alu_coms = ($signed(bus.alu_a) < $signed(bus.alu_b));
            4'hB: bus.alu_coms = (bus.alu_a == bus.alu_b);
            default: bus.alu_s = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = i[2:0];
            #1;
            check($sformatf("%s_r%0d", tag, i), {16'h0, dbg_data}, {16'h0, exp_rf[i]});
        end
    endtask

    // Called at #1 into cycle N with the controller idle; returns at #1 into the cycle it is idle again.
    task automatic do_instr(input string tag, input logic [15:0] word, input logic [3:0] op,
                            input logic [15:0] a, input logic [15:0] b, input logic [2:0] addr,
                            input logic [15:0] data, input logic ill);
        check({tag, "_ready_n"}, {31'h0, bus.instr_ready}, 32'h1);
        bus.instr_valid = 1'b1;
        bus.instr       = word;
        step();
        bus.instr_valid = 1'b0;
        bus.instr       = 16'hDEAD;
        check({tag, "_illegal_n1"}, {31'h0, illegal}, {31'h0, ill});
        check({tag, "_ready_n1"}, {31'h0, bus.instr_ready}, 32'h0);
        check({tag, "_wbv_n1"}, {31'h0, bus.wb_valid}, 32'h0);
        if (ill) begin
            step();
            check({tag, "_ready_n2"}, {31'h0, bus.instr_ready}, 32'h1);
            check({tag, "_illegal_n2"}, {31'h0, illegal}, 32'h0);
            check({tag, "_wbv_n2"}, {31'h0, bus.wb_valid}, 32'h0);
        end else begin
            step();
            check({tag, "_op"}, {28'h0, bus.alu_op}, {28'h0, op});
            check({tag, "_a"}, {16'h0, bus.alu_a}, {16'h0, a});
            check({tag, "_b"}, {16'h0, bus.alu_b}, {16'h0, b});
            check({tag, "_wbv_n2"}, {31'h0, bus.wb_valid}, 32'h0);
            step();
            check({tag, "_wbv_n3"}, {31'h0, bus.wb_valid}, 32'h1);
            check({tag, "_wbaddr"}, {29'h0, bus.wb_addr}, {29'h0, addr});
            check({tag, "_wbdata"}, {16'h0, bus.wb_data}, {16'h0, data});
            check({tag, "_illegal_n3"}, {31'h0, illegal}, 32'h0);
            check({tag, "_ready_n3"}, {31'h0, bus.instr_ready}, 32'h0);
            step();
            check({tag, "_wbv_n4"}, {31'h0, bus.wb_valid}, 32'h0);
            check({tag, "_ready_n4"}, {31'h0, bus.instr_ready}, 32'h1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0;
        dbg_addr        = 3'd0;
        for (int i = 0; i < 8; i++) exp_rf[i] = 16'h0;

        step();
        step();
        check("rst_ready", {31'h0, bus.instr_ready}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_op", {28'h0, bus.alu_op}, 32'h0);
        check("rst_a", {16'h0, bus.alu_a}, 32'h0);
        check("rst_b", {16'h0, bus.alu_b}, 32'h0);
        check("rst_wbv", {31'h0, bus.wb_valid}, 32'h0);
        check("rst_wbaddr", {29'h0, bus.wb_addr}, 32'h0);
        check("rst_wbdata", {16'h0, bus.wb_data}, 32'h0);
        check("rst_illegal", {31'h0, illegal}, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_ready_after", {31'h0, bus.instr_ready}, 32'h1);
        step();

        do_instr("ldi_r1", 16'hC205, 4'h3, 16'h0005, 16'h0000, 3'd1, 16'h0005, 1'b0);
        do_instr("ldi_r2", 16'hC403, 4'h3, 16'h0003, 16'h0000, 3'd2, 16'h0003, 1'b0);
        do_instr("add_r3", 16'h3650, 4'h3, 16'h0005, 16'h0003, 3'd3, 16'h0008, 1'b0);
        do_instr("sub_r4", 16'h4888, 4'h4, 16'h0003, 16'h0005, 3'd4, 16'hFFFE, 1'b0);
        do_instr("sll_r5", 16'h5A50, 4'h5, 16'h0005, 16'h0003, 3'd5, 16'h0028, 1'b0);
        do_instr("slt_r6", 16'hAC50, 4'hA, 16'h0005, 16'h0003, 3'd6, 16'h0000, 1'b0);
        do_instr("soe_r7", 16'hBE48, 4'hB, 16'h0005, 16'h0005, 3'd7, 16'h0001, 1'b0);

        exp_rf[1] = 16'h0005; exp_rf[2] = 16'h0003; exp_rf[3] = 16'h0008;
        exp_rf[4] = 16'hFFFE; exp_rf[5] = 16'h0028; exp_rf[6] = 16'h0000;
        exp_rf[7] = 16'h0001;
        check_rf("rf_a");
        step();

        do_instr("ill", 16'hE000, 4'h0, 16'h0, 16'h0, 3'd0, 16'h0, 1'b1);
        check({"ill", "_op_kept"}, {28'h0, bus.alu_op}, 32'hB);
        check_rf("rf_ill");
        step();

        do_instr("ldi_r0", 16'hC0FF, 4'h3, 16'h00FF, 16'h0000, 3'd0, 16'h00FF, 1'b0);
        check_rf("rf_r0");
        step();

        // Continuous instr_valid with a word change while busy.
        bus.instr_valid = 1'b1;
        bus.instr       = 16'hC211;
        check("hold_ready_n", {31'h0, bus.instr_ready}, 32'h1);
        step();
        bus.instr = 16'hC422;
        check("hold_ready_n1", {31'h0, bus.instr_ready}, 32'h0);
        step();
        check("hold_ready_n2", {31'h0, bus.instr_ready}, 32'h0);
        step();
        check("hold_wbv_n3", {31'h0, bus.wb_valid}, 32'h1);
        check("hold_wbaddr_a", {29'h0, bus.wb_addr}, 32'h1);
        check("hold_wbdata_a", {16'h0, bus.wb_data}, 32'h0011);
        check("hold_ready_n3", {31'h0, bus.instr_ready}, 32'h0);
        step();
        check("hold_ready_n4", {31'h0, bus.instr_ready}, 32'h1);
        check("hold_wbv_n4", {31'h0, bus.wb_valid}, 32'h0);
        step();
        bus.instr_valid = 1'b0;
        check("hold_busy_n5", {31'h0, busy}, 32'h1);
        step();
        step();
        check("hold_wbv_n7", {31'h0, bus.wb_valid}, 32'h1);
        check("hold_wbaddr_b", {29'h0, bus.wb_addr}, 32'h2);
        check("hold_wbdata_b", {16'h0, bus.wb_data}, 32'h0022);
        step();
        check("hold_ready_n8", {31'h0, bus.instr_ready}, 32'h1);

        // Reset asserted during EXEC of ADD R3,R1,R2.
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h3650;
        step();
        bus.instr_valid = 1'b0;
        step();
        check("rstx_op", {28'h0, bus.alu_op}, 32'h3);
        check("rstx_a", {16'h0, bus.alu_a}, 32'h0011);
        check("rstx_b", {16'h0, bus.alu_b}, 32'h0022);
        rst = 1'b1;
        #1;
        check("rstx_ready_hi", {31'h0, bus.instr_ready}, 32'h0);
        step();
        check("rstx_wbv", {31'h0, bus.wb_valid}, 32'h0);
        check("rstx_busy", {31'h0, busy}, 32'h0);
        check("rstx_op0", {28'h0, bus.alu_op}, 32'h0);
        check("rstx_a0", {16'h0, bus.alu_a}, 32'h0);
        check("rstx_ready", {31'h0, bus.instr_ready}, 32'h0);
        rst = 1'b0;
        #1;
        check("rstx_ready_after", {31'h0, bus.instr_ready}, 32'h1);
        for (int i = 0; i < 8; i++) exp_rf[i] = 16'h0;
        check_rf("rf_rst");
        step();
        check("rstx_wbv_after", {31'h0, bus.wb_valid}, 32'h0);
        check("rstx_illegal_after", {31'h0, illegal}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
